// File: rtl/wb_retire_stage.sv
// Dual-line writeback/retire stage: drives two regfile write ports combinationally
// and queues one trace entry per retiring line for an in-order debug consumer.
module wb_retire_stage #(
   parameter int FIFO_DEPTH = 4,
   parameter int PC_W       = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          line1_now_valid_i,
   input  logic                          line2_now_valid_i,
   input  logic [PC_W-1:0]               line1_pc_i,
   input  logic [PC_W-1:0]               line2_pc_i,
   input  logic                          line1_rf_we_i,
   input  logic                          line2_rf_we_i,
   input  logic [4:0]                    line1_rf_waddr_i,
   input  logic [4:0]                    line2_rf_waddr_i,
   input  logic [PC_W-1:0]               line1_rf_wdata_i,
   input  logic [PC_W-1:0]               line2_rf_wdata_i,
   output logic                          now_allowin_o,
   output logic                          rf_we1_o,
   output logic                          rf_we2_o,
   output logic [4:0]                    rf_waddr1_o,
   output logic [4:0]                    rf_waddr2_o,
   output logic [PC_W-1:0]               rf_wdata1_o,
   output logic [PC_W-1:0]               rf_wdata2_o,
   input  logic                          debug_ready_i,
   output logic                          debug_wb_valid_o,
   output logic [PC_W-1:0]               debug_wb_pc_o,
   output logic [3:0]                    debug_wb_rf_we_o,
   output logic [4:0]                    debug_wb_rf_wnum_o,
   output logic [PC_W-1:0]               debug_wb_rf_wdata_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            we;
      logic [4:0]      waddr;
      logic [PC_W-1:0] wdata;
   } trace_t;

   trace_t          mem [FIFO_DEPTH];
   trace_t          head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            retire1;
   logic            retire2;
   logic            pop;
   logic [1:0]      n_push;
   logic [CW:0]     occ_after;

   // Credit comes only from the registered count so a dual push always fits.
   assign now_allowin_o = (count <= CW'(FIFO_DEPTH - 2));
   assign retire1       = line1_now_valid_i & now_allowin_o;
   assign retire2       = line2_now_valid_i & now_allowin_o;

   assign rf_we2_o    = retire2 & line2_rf_we_i & (line2_rf_waddr_i != 5'd0);
   assign rf_we1_o    = retire1 & line1_rf_we_i & (line1_rf_waddr_i != 5'd0)
                      & ~(rf_we2_o & (line1_rf_waddr_i == line2_rf_waddr_i));
   assign rf_waddr1_o = line1_rf_waddr_i;
   assign rf_waddr2_o = line2_rf_waddr_i;
   assign rf_wdata1_o = line1_rf_wdata_i;
   assign rf_wdata2_o = line2_rf_wdata_i;

   assign n_push    = {1'b0, retire1} + {1'b0, retire2};
   assign pop       = debug_wb_valid_o & debug_ready_i;
   assign occ_after = {1'b0, count} + (CW+1)'(n_push);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(n_push) - CW'(pop);
      end
   end

   // Line1 is older, so it takes the lower slot when both retire.
   always_ff @(posedge clk) begin
      if (retire1)
         mem[wr_ptr] <= {line1_pc_i, line1_rf_we_i, line1_rf_waddr_i, line1_rf_wdata_i};
      if (retire2)
         mem[retire1 ? wr_ptr + AW'(1) : wr_ptr] <=
            {line2_pc_i, line2_rf_we_i, line2_rf_waddr_i, line2_rf_wdata_i};
   end

   assign head                = mem[rd_ptr];
   assign debug_wb_valid_o    = (count != '0);
   assign debug_wb_pc_o       = debug_wb_valid_o ? head.pc : '0;
   assign debug_wb_rf_wnum_o  = debug_wb_valid_o ? head.waddr : 5'd0;
   assign debug_wb_rf_wdata_o = debug_wb_valid_o ? head.wdata : '0;
   assign debug_wb_rf_we_o    = (debug_wb_valid_o & head.we & (head.waddr != 5'd0)) ? 4'hF : 4'h0;
   assign fifo_count_o        = count;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      occ_after <= (CW+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: regfile port behaviour, trace ordering,
// backpressure credit, pointer wrap and asynchronous reset.
module tb_wb_retire_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        l1_v, l2_v, l1_we, l2_we;
   logic [31:0] l1_pc, l2_pc, l1_wd, l2_wd;
   logic [4:0]  l1_wa, l2_wa;
   logic        allowin, we1, we2;
   logic [4:0]  wa1, wa2;
   logic [31:0] wd1, wd2;
   logic        ready;
   logic        dvalid;
   logic [31:0] dpc, dwdata;
   logic [3:0]  dwe;
   logic [4:0]  dwnum;
   logic [2:0]  count;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   wb_retire_stage #(.FIFO_DEPTH(4), .PC_W(32)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .line1_now_valid_i   (l1_v),
      .line2_now_valid_i   (l2_v),
      .line1_pc_i          (l1_pc),
      .line2_pc_i          (l2_pc),
      .line1_rf_we_i       (l1_we),
      .line2_rf_we_i       (l2_we),
      .line1_rf_waddr_i    (l1_wa),
      .line2_rf_waddr_i    (l2_wa),
      .line1_rf_wdata_i    (l1_wd),
      .line2_rf_wdata_i    (l2_wd),
      .now_allowin_o       (allowin),
      .rf_we1_o            (we1),
      .rf_we2_o            (we2),
      .rf_waddr1_o         (wa1),
      .rf_waddr2_o         (wa2),
      .rf_wdata1_o         (wd1),
      .rf_wdata2_o         (wd2),
      .debug_ready_i       (ready),
      .debug_wb_valid_o    (dvalid),
      .debug_wb_pc_o       (dpc),
      .debug_wb_rf_we_o    (dwe),
      .debug_wb_rf_wnum_o  (dwnum),
      .debug_wb_rf_wdata_o (dwdata),
      .fifo_count_o        (count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      l1_v = 0; l2_v = 0;
   endtask

   task automatic set_l1(input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      l1_v = 1; l1_pc = pc; l1_we = we; l1_wa = wa; l1_wd = wd;
   endtask

   task automatic set_l2(input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      l2_v = 1; l2_pc = pc; l2_we = we; l2_wa = wa; l2_wd = wd;
   endtask

   task automatic drain();
      ready = 1; idle();
      for (int i = 0; i < 8 && count != 0; i++) tick();
      chk("drain_empty", count, 0);
   endtask

   initial begin
      rst_n = 0; ready = 0;
      l1_v = 0; l2_v = 0; l1_we = 0; l2_we = 0;
      l1_pc = 0; l2_pc = 0; l1_wd = 0; l2_wd = 0; l1_wa = 0; l2_wa = 0;
      #2;
      chk("rst_allowin", allowin, 1);
      chk("rst_valid", dvalid, 0);
      chk("rst_count", count, 0);
      chk("rst_pc", dpc, 0);
      chk("rst_we", dwe, 0);
      tick(); tick();
      rst_n = 1;
      tick();

      // dual retire, distinct registers
      ready = 1;
      set_l1(32'h1c000000, 1, 5'd4, 32'h11);
      set_l2(32'h1c000004, 1, 5'd5, 32'h22);
      #1;
      chk("dual_we1", we1, 1);
      chk("dual_we2", we2, 1);
      chk("dual_wa1", wa1, 4);
      chk("dual_wd2", wd2, 32'h22);
      tick(); idle();
      chk("dual_cnt2", count, 2);
      chk("dual_pc0", dpc, 32'h1c000000);
      chk("dual_wnum0", dwnum, 4);
      chk("dual_wd0", dwdata, 32'h11);
      chk("dual_we0", dwe, 4'hF);
      tick();
      chk("dual_cnt1", count, 1);
      chk("dual_pc1", dpc, 32'h1c000004);
      chk("dual_wnum1", dwnum, 5);
      tick();
      chk("empty_valid", dvalid, 0);
      chk("empty_pc", dpc, 0);
      chk("empty_wnum", dwnum, 0);
      chk("empty_wdata", dwdata, 0);
      chk("empty_we", dwe, 0);

      // same destination on both lines
      set_l1(32'h200, 1, 5'd7, 32'hA);
      set_l2(32'h204, 1, 5'd7, 32'hB);
      #1;
      chk("waw_we1", we1, 0);
      chk("waw_we2", we2, 1);
      chk("waw_wd2", wd2, 32'hB);
      tick(); idle();
      chk("waw_t0_we", dwe, 4'hF);
      chk("waw_t0_wd", dwdata, 32'hA);
      tick();
      chk("waw_t1_we", dwe, 4'hF);
      chk("waw_t1_wd", dwdata, 32'hB);
      drain();

      // write to r0 still traces
      set_l1(32'h300, 1, 5'd0, 32'h55);
      #1;
      chk("r0_we1", we1, 0);
      tick(); idle();
      chk("r0_valid", dvalid, 1);
      chk("r0_pc", dpc, 32'h300);
      chk("r0_we", dwe, 4'h0);
      drain();

      // invalid lines do nothing
      l1_v = 0; l2_v = 0; l1_we = 1; l1_wa = 5'd3; l2_we = 1; l2_wa = 5'd6;
      #1;
      chk("inv_we1", we1, 0);
      chk("inv_we2", we2, 0);
      tick();
      chk("inv_cnt", count, 0);

      // backpressure
      ready = 0;
      set_l1(32'h400, 1, 5'd1, 32'h1);
      set_l2(32'h404, 1, 5'd2, 32'h2);
      #1;
      chk("bp_allow0", allowin, 1);
      tick();
      chk("bp_cnt2", count, 2);
      chk("bp_allow2", allowin, 1);
      set_l1(32'h408, 1, 5'd1, 32'h3);
      set_l2(32'h40c, 1, 5'd2, 32'h4);
      tick();
      chk("bp_cnt4", count, 4);
      chk("bp_allow4", allowin, 0);
      chk("bp_blk_we1", we1, 0);
      chk("bp_blk_we2", we2, 0);
      tick();
      chk("bp_hold4", count, 4);
      chk("bp_head0", dpc, 32'h400);
      ready = 1;
      #1;
      chk("bp_nocredit", allowin, 0);
      tick();
      chk("bp_cnt3", count, 3);
      chk("bp_allow3", allowin, 0);
      chk("bp_head1", dpc, 32'h404);
      idle();
      tick();
      chk("bp_cnt2b", count, 2);
      chk("bp_allow2b", allowin, 1);
      chk("bp_head2", dpc, 32'h408);
      tick();
      chk("bp_head3", dpc, 32'h40c);
      drain();

      // pointer wrap with alternating single-line retires
      ready = 1;
      for (int i = 0; i < 10; i++) begin
         idle();
         if (i % 2 == 0) set_l1(32'h1000 + 32'(4 * i), 1, 5'd8, 32'(i));
         else            set_l2(32'h1000 + 32'(4 * i), 1, 5'd9, 32'(i));
         #1;
         if (i > 0) chk("wrap_pc", dpc, 32'h1000 + 32'(4 * (i - 1)));
         tick();
      end
      idle();
      chk("wrap_last", dpc, 32'h1000 + 32'(4 * 9));
      chk("wrap_cnt", count, 1);
      drain();

      // async reset with count=3
      ready = 0;
      set_l1(32'h500, 1, 5'd1, 32'h1);
      set_l2(32'h504, 1, 5'd2, 32'h2);
      tick();
      l2_v = 0;
      tick();
      idle();
      chk("ar_cnt3", count, 3);
      chk("ar_allow3", allowin, 0);
      #2;
      rst_n = 0;
      #1;
      chk("ar_cnt", count, 0);
      chk("ar_valid", dvalid, 0);
      chk("ar_allow", allowin, 1);
      tick();
      rst_n = 1;
      set_l1(32'h600, 1, 5'd9, 32'h99);
      #1;
      chk("ar_rf_we1", we1, 1);
      chk("ar_rf_wd1", wd1, 32'h99);
      tick(); idle();
      chk("ar_fresh_cnt", count, 1);
      chk("ar_fresh_pc", dpc, 32'h600);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
